exc_arbiter: RTL
================

# exc_arbiter

Registered, parametrised exception arbiter for the MEM stage, generalising the combinational exception selector. It arbitrates NUM_SRC prioritised exception sources plus synchronised hardware interrupts, and commits one event per handshake through a small FSM. It then issues a one-cycle CP0 write/flush and holds a redirect request to fetch until acknowledged. It sits between MEM-stage exception flags, CP0 and the IF redirect mux.

## Interface
Parameters:
- NUM_SRC, 16, number of synchronous exception sources; bit 0 has the highest priority.
- NUM_HW_INT, 6, hardware interrupt lines, mapped to Cause.IP[7:2].
- BOOT_VEC, 32'hBFC00000, base used when BEV=1, or always when EXC_EBASE_EN is undefined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_valid  in  1  MEM holds a real instruction.
- m_src_vec  in  NUM_SRC  exception source flags.
- m_src_code  in  5*NUM_SRC  ExcCode per source.
- m_src_kind  in  2*NUM_SRC  exc_kind_t per source.
- m_eret  in  1  ERET in MEM.
- m_pc, m_badvaddr  in  32 each  PC and faulting address.
- m_in_delay_slot  in  1  instruction is in a branch delay slot.
- hw_int  in  NUM_HW_INT  asynchronous interrupt lines.
- cp0_status, cp0_cause, cp0_epc, cp0_ebase  in  32 each  current CP0 values.
- if_ready  in  1  fetch accepts the redirect.
- m_stall  out  1  state != IDLE.
- flush  out  1  pipeline flush pulse.
- cp0_we  out  1  CP0 update pulse.
- exc_info  out  exc_info_t  fields: exccode, epc, bd, badvaddr, badva_we, tlb_we, is_eret.
- exc_req  out  1  redirect valid.
- exc_addr  out  32  redirect target.
- int_sync  out  NUM_HW_INT  synchronised interrupt lines, feeding Cause.IP.

## Operation
- hw_int passes through a 2-flop synchronizer; int_sync is the second flop.
- Interrupt pending = ((({int_sync, cp0_cause[9:8]} & cp0_status[15:8]) != 0) && IE && !EXL && !ERL).
- FSM states: IDLE, COMMIT, REDIRECT.
- IDLE with m_valid: the highest-priority event is latched and the FSM moves to COMMIT.
  - Priority: interrupt (ExcCode 0), then the lowest set bit of m_src_vec, then m_eret.
  - With none of these present, the FSM stays in IDLE.
- COMMIT:
  - cp0_we=1 and flush=1 for exactly one cycle.
  - exc_info fields come from registers; the FSM moves to REDIRECT.
- REDIRECT:
  - exc_req=1 and exc_addr are held stable until if_ready=1 is sampled, then the FSM returns to IDLE.
- exc_kind_t values:
  - PLAIN: no extra CP0 writes.
  - BADVA: badva_we=1.
  - TLB: badva_we=1, tlb_we=1 (EntryHi/Context).
  - REFILL: as TLB, plus the refill vector.
- EPC/BD:
  - EXL=1: epc=cp0_epc, bd=cp0_cause[31].
  - EXL=0 in a delay slot: epc=m_pc-4, bd=1.
  - Otherwise: epc=m_pc, bd=0.
- ERET: is_eret=1, exccode=0, no BadVAddr write, exc_addr=cp0_epc.
- Vector, exceptions only: base+0x200 if kind==REFILL && !EXL, else base+0x380. The EXC_EBASE_EN variant is under Configuration.
- m_valid=0 in IDLE: no action. Sources, interrupts and ERET are all ignored.
- Inputs are not sampled outside IDLE; MEM is stalled by m_stall.

## Timing
- Accept edge T, latching the event. Cycle T+1: COMMIT. Cycle T+2 onward: REDIRECT. Minimum occupancy is 3 cycles per event.
- Interrupt latency: hw_int edge to pending is 2 clk edges.
- Reset (async, any state) forces:
  - state=IDLE;
  - m_stall, flush, cp0_we and exc_req all 0;
  - exc_addr=BOOT_VEC+0x380;
  - exc_info all zero;
  - synchronizer flops 0.
- if_ready high during COMMIT is ignored. if_ready low holds REDIRECT indefinitely.
- Interrupt and a synchronous source in the same cycle: the interrupt wins, and the source is dropped (the instruction is flushed).

## Configuration
- EXC_EBASE_EN defined: when cp0_status[22] (BEV) is 0, base={cp0_ebase[31:12],12'h000}, the refill offset is 0x000 and the general offset is 0x180. When BEV=1, BOOT_VEC offsets apply.
- EXC_EBASE_EN undefined: cp0_ebase is unused and BOOT_VEC offsets always apply.

## Structure
- Package cpu_defs holds:
  - exc_kind_t {PLAIN, BADVA, TLB, REFILL} and exc_state_t;
  - exc_info_t;
  - EXCCODE_* constants;
  - the OFS_REFILL/OFS_GENERAL/OFS_EBASE_* constants.
- One sub-module, exc_prio_enc: parametrised lowest-set-bit encoder producing a valid flag and an index, width NUM_SRC.

## Test plan
- Source bit 3 (ADEL code 4, BADVA) with m_pc=0x80001000, not in a delay slot → after 1 cycle: cp0_we=flush=1, exccode=4, epc=0x80001000, badva_we=1. Next cycle: exc_req=1, exc_addr=0xBFC00380.
- Bits 2 and 5 set, bit 5 REFILL, EXL=0 → bit 2 wins. Bit 5 alone → exc_addr=0xBFC00200, tlb_we=1.
- Pulse hw_int[0] with Status=0x0000_0401 → commit 2 cycles later with exccode 0. The same with EXL=1 gives no commit.
- Delay slot, m_pc=0x80000104 → epc=0x80000100, bd=1. With EXL=1 → epc=cp0_epc, bd=cp0_cause[31].
- if_ready held low 5 cycles in REDIRECT → exc_req and exc_addr stable, m_stall=1. Assert rst mid-REDIRECT → all outputs reset on the same edge.
- EXC_EBASE_EN, BEV=0, EBase=0x80000000 → general 0x80000180, refill 0x80000000. ERET with cp0_epc=0x80002000 → exc_addr=0x80002000, is_eret=1.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared types and constants for the MEM-stage exception arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_defs;

    typedef enum logic [1:0] {
        PLAIN  = 2'd0,
        BADVA  = 2'd1,
        TLB    = 2'd2,
        REFILL = 2'd3
    } exc_kind_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        REDIRECT = 2'd2
    } exc_state_t;

    typedef struct packed {
        logic [4:0]  exccode;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] badvaddr;
        logic        badva_we;
        logic        tlb_we;
        logic        is_eret;
    } exc_info_t;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_MOD  = 5'd1;
    localparam logic [4:0] EXCCODE_TLBL = 5'd2;
    localparam logic [4:0] EXCCODE_TLBS = 5'd3;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    // Vector offsets relative to the boot base and to EBase
    localparam logic [31:0] OFS_REFILL        = 32'h0000_0200;
    localparam logic [31:0] OFS_GENERAL       = 32'h0000_0380;
    localparam logic [31:0] OFS_EBASE_REFILL  = 32'h0000_0000;
    localparam logic [31:0] OFS_EBASE_GENERAL = 32'h0000_0180;

    // Every kind except PLAIN records the faulting address
    function automatic logic kind_writes_badva(input exc_kind_t k);
        return k != PLAIN;
    endfunction

    // TLB-class kinds also update EntryHi/Context
    function automatic logic kind_writes_tlb(input exc_kind_t k);
        return (k == TLB) || (k == REFILL);
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins, vld flags any bit set.
// Latency: combinational.
// Backpressure: none.
module exc_prio_enc #(
    parameter int W = 16,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last writer
    always_comb begin
        vld = |vec;
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/exc_arbiter.sv
// Registered MEM-stage exception/interrupt/ERET arbiter; EXC_EBASE_EN selects EBase-relative vectors when BEV=0.
// Latency: accept edge T, CP0 write + flush in cycle T+1, redirect from T+2 (>= 3 cycles per event).
// Backpressure: redirect held until if_ready; m_stall freezes MEM whenever the FSM is busy.
module exc_arbiter
    import cpu_defs::*;
#(
    parameter int          NUM_SRC    = 16,
    parameter int          NUM_HW_INT = 6,
    parameter logic [31:0] BOOT_VEC   = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_valid,
    input  logic [NUM_SRC-1:0]     m_src_vec,
    input  logic [5*NUM_SRC-1:0]   m_src_code,
    input  logic [2*NUM_SRC-1:0]   m_src_kind,
    input  logic                   m_eret,
    input  logic [31:0]            m_pc,
    input  logic [31:0]            m_badvaddr,
    input  logic                   m_in_delay_slot,
    input  logic [NUM_HW_INT-1:0]  hw_int,
    input  logic [31:0]            cp0_status,
    input  logic [31:0]            cp0_cause,
    input  logic [31:0]            cp0_epc,
    input  logic [31:0]            cp0_ebase,
    input  logic                   if_ready,
    output logic                   m_stall,
    output logic                   flush,
    output logic                   cp0_we,
    output exc_info_t              exc_info,
    output logic                   exc_req,
    output logic [31:0]            exc_addr,
    output logic [NUM_HW_INT-1:0]  int_sync
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    exc_state_t            state, state_nxt;
    logic [NUM_HW_INT-1:0] int_meta, int_sync_q;
    logic [7:0]            ip_vec;
    logic                  int_pend, src_vld, accept, exl;
    logic [IW-1:0]         src_idx;
    logic [4:0]            sel_code;
    exc_kind_t             sel_kind;
    logic [31:0]           base, ofs_ref, ofs_gen, ev_epc, ev_addr;
    logic                  ev_bd;
    exc_info_t             ev_info;
    logic                  unused_cp0;

    // Only some CP0 bits matter here; the rest are deliberately ignored
    assign unused_cp0 = ^{cp0_status, cp0_cause, cp0_ebase};

    // Two-flop synchronizer for the asynchronous interrupt lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_meta   <= '0;
            int_sync_q <= '0;
        end else begin
            int_meta   <= hw_int;
            int_sync_q <= int_meta;
        end
    end

    assign int_sync = int_sync_q;

    // Build Cause.IP: software bits [1:0], hardware lines from bit 2 up
    always_comb begin
        ip_vec = {6'b0, cp0_cause[9:8]};
        for (int i = 0; i < NUM_HW_INT && i < 6; i++) begin
            ip_vec[i+2] = int_sync_q[i];
        end
    end

    assign exl      = cp0_status[1];
    assign int_pend = (|(ip_vec & cp0_status[15:8])) && cp0_status[0] && !exl && !cp0_status[2];

    exc_prio_enc #(.W(NUM_SRC)) u_prio (
        .vec (m_src_vec),
        .vld (src_vld),
        .idx (src_idx)
    );

    assign sel_code = m_src_code[int'(src_idx)*5 +: 5];
    assign sel_kind = exc_kind_t'(m_src_kind[int'(src_idx)*2 +: 2]);
    assign accept   = (state == IDLE) && m_valid && (int_pend || src_vld || m_eret);

    // Resolve the winning event, its EPC/BD and its redirect target
    always_comb begin
        base    = BOOT_VEC;
        ofs_ref = OFS_REFILL;
        ofs_gen = OFS_GENERAL;
`ifdef EXC_EBASE_EN
        if (!cp0_status[22]) begin
            base    = {cp0_ebase[31:12], 12'h000};
            ofs_ref = OFS_EBASE_REFILL;
            ofs_gen = OFS_EBASE_GENERAL;
        end
`endif
        // A nested exception keeps the original EPC/BD
        if (exl) begin
            ev_epc = cp0_epc;
            ev_bd  = cp0_cause[31];
        end else if (m_in_delay_slot) begin
            ev_epc = m_pc - 32'd4;
            ev_bd  = 1'b1;
        end else begin
            ev_epc = m_pc;
            ev_bd  = 1'b0;
        end

        ev_info = '0;
        ev_addr = base + ofs_gen;
        if (int_pend) begin
            ev_info.exccode = EXCCODE_INT;
            ev_info.epc     = ev_epc;
            ev_info.bd      = ev_bd;
        end else if (src_vld) begin
            ev_info.exccode  = sel_code;
            ev_info.epc      = ev_epc;
            ev_info.bd       = ev_bd;
            ev_info.badvaddr = m_badvaddr;
            ev_info.badva_we = kind_writes_badva(sel_kind);
            ev_info.tlb_we   = kind_writes_tlb(sel_kind);
            if (sel_kind == REFILL && !exl) ev_addr = base + ofs_ref;
        end else if (m_eret) begin
            ev_info.is_eret = 1'b1;
            ev_addr         = cp0_epc;
        end
    end

    // Latch the event on accept; held stable through COMMIT and REDIRECT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_info <= '0;
            exc_addr <= BOOT_VEC + OFS_GENERAL;
        end else if (accept) begin
            exc_info <= ev_info;
            exc_addr <= ev_addr;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: commit is always one cycle, redirect waits for fetch
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = COMMIT;
            COMMIT:   state_nxt = REDIRECT;
            REDIRECT: if (if_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM outputs decoded purely from state
    always_comb begin
        m_stall = (state != IDLE);
        flush   = (state == COMMIT);
        cp0_we  = (state == COMMIT);
        exc_req = (state == REDIRECT);
    end

endmodule
